// File: rtl/mul_status_reg_pkg.sv
// Shared constants and types for the multiplier status register block.
package mul_stat_pkg;

  // ASTAT multiplier view bit positions
  localparam int ASTAT_MN = 0;
  localparam int ASTAT_MV = 1;

  // STKY view bit positions
  localparam int STKY_MOS = 0;
  localparam int STKY_SSO = 1;
  localparam int STKY_SSE = 2;

  // Decode-stage multiplier class / sub-class encodings
  localparam logic [1:0] CLS_XFER = 2'b00;
  localparam logic [1:0] CLS_PROD = 2'b01;
  localparam logic [1:0] SC_SAT   = 2'b11;

  // One status-stack entry
  typedef struct packed {
    logic mn;
    logic mv;
  } stat_entry_t;

endpackage

// File: rtl/mul_status_reg_if.sv
// Control, flag and universal-register bus signals of mul_status_reg.
interface mul_status_reg_if #(
  parameter int RF_DATASIZE = 16
);
  logic                   ps_mul_en;
  logic [1:0]             ps_mul_cls;
  logic [1:0]             ps_mul_sc;
  logic                   mul_ps_mv;
  logic                   mul_ps_mn;
  logic                   ps_stat_wen;
  logic                   ps_stat_ren;
  logic                   ps_stat_sel;
  logic [RF_DATASIZE-1:0] xb_dt;
  logic                   ps_stat_push;
  logic                   ps_stat_pop;
  logic [RF_DATASIZE-1:0] stat_xb_dt;
  logic                   ps_cond_mv;
  logic                   ps_cond_mn;
  logic                   ps_mos;
  logic                   mul_ovf_evt;

  // Sequencer / multiplier side drives controls and observes status
  modport master (
    output ps_mul_en, ps_mul_cls, ps_mul_sc, mul_ps_mv, mul_ps_mn,
           ps_stat_wen, ps_stat_ren, ps_stat_sel, xb_dt,
           ps_stat_push, ps_stat_pop,
    input  stat_xb_dt, ps_cond_mv, ps_cond_mn, ps_mos, mul_ovf_evt
  );

  // Status register side
  modport slave (
    input  ps_mul_en, ps_mul_cls, ps_mul_sc, mul_ps_mv, mul_ps_mn,
           ps_stat_wen, ps_stat_ren, ps_stat_sel, xb_dt,
           ps_stat_push, ps_stat_pop,
    output stat_xb_dt, ps_cond_mv, ps_cond_mn, ps_mos, mul_ovf_evt
  );
endinterface

// File: rtl/mul_status_reg_stat_stack.sv
// Small LIFO of {MN,MV} entries used across interrupt entry and exit.
// Push and pop together is a no-op; overflow/underflow leave the stack
// untouched and raise err for the caller's sticky bit.
module stat_stack
  import mul_stat_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  stat_entry_t din,
  output stat_entry_t top,
  output logic        empty,
  output logic        pop_ok,
  output logic        err
);
  localparam int PW = $clog2(DEPTH + 1);

  logic [PW-1:0] ptr_reg;
  stat_entry_t   mem_reg [DEPTH];
  logic          full;
  logic          push_ok;

  assign empty   = (ptr_reg == '0);
  assign full    = (ptr_reg == PW'(DEPTH));
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign err     = (push & ~pop & full) | (pop & ~push & empty);

  // Top-of-stack entry, decoded from the pointer without wrap-around
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr_reg == PW'(i + 1)) top = mem_reg[i];
    end
  end

  // Pointer and entry storage
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      if (push_ok) ptr_reg <= ptr_reg + 1'b1;
      else if (pop_ok) ptr_reg <= ptr_reg - 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok && ptr_reg == PW'(i)) mem_reg[i] <= din;
      end
    end
  end

endmodule

// File: rtl/mul_status_reg.sv
// Multiplier status register: execute-aligned MN/MV flags, sticky MOS/SSO,
// status stack and universal-register bus access.
module mul_status_reg
  import mul_stat_pkg::*;
#(
  parameter int RF_DATASIZE = 16,
  parameter int STACK_DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  mul_status_reg_if.slave  bus
);
  logic        upd_en_reg;
  logic        mn_reg, mv_reg, mos_reg, sso_reg, evt_reg;
  logic        mn_next, mv_next, mos_next, sso_next, evt_next;
  logic        wr_astat, wr_stky, flag_ov;
  logic        stk_empty, stk_pop_ok, stk_err;
  stat_entry_t stk_top, stk_din;
  logic [RF_DATASIZE-1:0] rd_data;

  assign wr_astat = bus.ps_stat_wen & ~bus.ps_stat_sel;
  assign wr_stky  = bus.ps_stat_wen &  bus.ps_stat_sel;
  assign flag_ov  = upd_en_reg & bus.mul_ps_mv;
  assign stk_din  = '{mn: mn_reg, mv: mv_reg};

  stat_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk    (clk),
    .reset  (reset),
    .push   (bus.ps_stat_push),
    .pop    (bus.ps_stat_pop),
    .din    (stk_din),
    .top    (stk_top),
    .empty  (stk_empty),
    .pop_ok (stk_pop_ok),
    .err    (stk_err)
  );

  // Next-state for flags and sticky bits: update beats pop beats bus write
  always_comb begin
    mn_next = mn_reg;
    mv_next = mv_reg;
    if (upd_en_reg) begin
      mn_next = bus.mul_ps_mn;
      mv_next = bus.mul_ps_mv;
    end else if (stk_pop_ok) begin
      mn_next = stk_top.mn;
      mv_next = stk_top.mv;
    end else if (wr_astat) begin
      mn_next = bus.xb_dt[ASTAT_MN];
      mv_next = bus.xb_dt[ASTAT_MV];
    end
    // A same-cycle overflow is OR'd in after the write so it is never lost
    mos_next = (wr_stky ? bus.xb_dt[STKY_MOS] : mos_reg) | flag_ov;
    sso_next = (wr_stky ? bus.xb_dt[STKY_SSO] : sso_reg) | stk_err;
    evt_next = flag_ov & ~mos_reg;
  end

  // Decode-to-execute alignment and architectural state
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_en_reg <= 1'b0;
      mn_reg     <= 1'b0;
      mv_reg     <= 1'b0;
      mos_reg    <= 1'b0;
      sso_reg    <= 1'b0;
      evt_reg    <= 1'b0;
    end else begin
      // MR transfers leave the flags alone; SAT MR, product, accumulate do not
      upd_en_reg <= bus.ps_mul_en &
                    ~(bus.ps_mul_cls == CLS_XFER && bus.ps_mul_sc != SC_SAT);
      mn_reg     <= mn_next;
      mv_reg     <= mv_next;
      mos_reg    <= mos_next;
      sso_reg    <= sso_next;
      evt_reg    <= evt_next;
    end
  end

  // Combinational read mux of the current (pre-edge) register values
  always_comb begin
    rd_data = '0;
    if (bus.ps_stat_ren) begin
      if (bus.ps_stat_sel) begin
        rd_data[STKY_MOS] = mos_reg;
        rd_data[STKY_SSO] = sso_reg;
        rd_data[STKY_SSE] = stk_empty;
      end else begin
        rd_data[ASTAT_MN] = mn_reg;
        rd_data[ASTAT_MV] = mv_reg;
      end
    end
  end

  assign bus.stat_xb_dt  = rd_data;
  assign bus.ps_cond_mv  = mv_reg;
  assign bus.ps_cond_mn  = mn_reg;
  assign bus.ps_mos      = mos_reg;
  assign bus.mul_ovf_evt = evt_reg;

endmodule

// File: doc/mul_status_reg.md
Name: mul_status_reg

Overview:
- Downstream consumer of the multiplier's MV/MN flag outputs.
- Aligns decode-stage multiplier control to the execute cycle and maintains architectural MN/MV status bits (ASTAT multiplier view).
- Maintains sticky MOS/SSO bits (STKY view) and a small status stack for interrupt entry and exit.
- Supplies the program sequencer with condition bits and a one-cycle overflow event; provides universal-register read/write access over the data bus.

Parameters:
RF_DATASIZE, 16, width of the bus read/write data.
STACK_DEPTH, 4, number of {MN,MV} entries in the status stack (must be 2..15).

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high; clears all state on the rising edge while high
ps_mul_en  in  1  decode-stage multiplier enable (same signal the multiplier receives)
ps_mul_cls  in  2  decode-stage multiplier class (00 transfer/SAT, 01 product, 10/11 accumulate)
ps_mul_sc  in  2  decode-stage sub-class when class is 00 (11 = SAT MR)
mul_ps_mv  in  1  multiplier overflow flag, valid in the execute cycle
mul_ps_mn  in  1  multiplier sign flag, valid in the execute cycle
ps_stat_wen  in  1  universal-register write strobe
ps_stat_ren  in  1  universal-register read enable
ps_stat_sel  in  1  register select: 0 = ASTAT view, 1 = STKY view
xb_dt  in  RF_DATASIZE  write data
ps_stat_push  in  1  push {MN,MV} onto the status stack
ps_stat_pop  in  1  pop the status stack into {MN,MV}
stat_xb_dt  out  RF_DATASIZE  read data
ps_cond_mv  out  1  current ASTAT MV
ps_cond_mn  out  1  current ASTAT MN
ps_mos  out  1  sticky multiplier overflow
mul_ovf_evt  out  1  one-cycle pulse when MOS is newly set by a flag update

Behaviour:
- Reset (synchronous, high): MN, MV, MOS, SSO, the stack pointer, the stack contents, the pipeline register and mul_ovf_evt all become 0. An update in flight is discarded. All outputs read 0 in the following cycle; stat_xb_dt is 0 whenever ps_stat_ren is 0.
- Pipeline register: upd_en is registered as ps_mul_en & ~(ps_mul_cls==00 & ps_mul_sc!=11).
  - Transfers to/from MR never touch flags; SAT MR, product and accumulate do.
- Flag update: in a cycle with upd_en=1, the next edge loads MV<=mul_ps_mv, MN<=mul_ps_mn, and MOS<=MOS|mul_ps_mv.
  - Latency: decode edge N, execute cycle N+1, flags visible in cycle N+2.
  - With upd_en=0, the flags hold.
- mul_ovf_evt: registered; 1 for exactly one cycle after an edge where a flag update sets MOS from 0 to 1. Writes and pops never pulse it.
- Register map (bit positions are package constants; unlisted bits read 0 and ignore writes):
  - ASTAT: bit0 MN, bit1 MV.
  - STKY: bit0 MOS, bit1 SSO (sticky stack error), bit2 SSE (live "stack empty", read-only).
- Write: ps_stat_wen loads the selected view's writable bits from xb_dt at the edge.
- Read: stat_xb_dt is a combinational mux of current register values, so a read in the same cycle as an update returns the pre-edge value.
- ASTAT priority in one cycle: flag update > pop > bus write.
- STKY MOS in one cycle: next = (written value if write, else MOS) | (upd_en & mul_ps_mv). An overflow is never lost.
- Push:
  - When not full, stores the pre-edge {MN,MV} at the stack pointer and increments the pointer.
  - When full (pointer==STACK_DEPTH), the stack is unchanged and SSO is set.
- Pop:
  - When not empty, decrements the pointer and loads {MN,MV} from the top entry (unless a flag update overrides).
  - When empty, ASTAT and the stack are unchanged and SSO is set.
- Push and pop together: no-op; the pointer, stack and SSO are unchanged.
- A bus write to SSO wins over a same-cycle stack error only when it writes 1; a stack error always sets SSO.
- Pointer width is $clog2(STACK_DEPTH+1). SSE = (pointer==0). There is no wrap-around.

Decomposition:
- Shared package (mul_stat_pkg): ASTAT/STKY bit-index constants, the class/sub-class encodings (CLS_XFER=00, CLS_PROD=01, SC_SAT=11), and the status-stack entry type {mn,mv}.
- One natural sub-module: stat_stack (the parameterised LIFO with push/pop, full/empty and error outputs). The flag, sticky and bus logic stays in the top level.

Test Plan:
- Decode edge with product enabled (en=1, cls=01), mul_ps_mv=1 and mul_ps_mn=1 in the next cycle -> MV=MN=MOS=1 two cycles after decode; mul_ovf_evt high for exactly that one cycle.
- Decode with en=1, cls=00, sc=01, and the flag inputs forced to 1 -> MN/MV/MOS stay 0. Repeat with sc=11 -> flags update.
- MOS=0, STKY write of 0 in the same cycle as an update with mv=1 -> MOS=1 and mul_ovf_evt pulses. An ASTAT write of 0b00 colliding with an update (mv=1, mn=0) -> MV=1, MN=0.
- Push 4 times with distinct {MN,MV} values, then push a 5th -> SSO=1, pointer stays 4. Pop 4 times -> ASTAT restored in LIFO order and SSE=1. A 5th pop -> ASTAT unchanged.
- Push and pop asserted together at pointer 2 -> pointer still 2, SSO still 0. Read STKY with ren=1 -> 0b000; with ren=0 -> 0.
- Reset asserted during the execute cycle of a product with mv=1 -> all state is 0 after the edge, no mul_ovf_evt pulse, and MOS remains 0 after reset is released.
